// File: rtl/quad_gen.sv
// quad_gen -- quadrature encoder signal generator.
//
// Steps an emulated encoder from its current position toward a requested
// target. Each position change is one quadrature phase transition on
// (enc_a, enc_b). Consecutive transitions are spaced max(period, MIN_PERIOD)+1
// clocks apart, so a downstream debounce filter always sees stable phases.
//
// Optional feature: define QUAD_GEN_INDEX_EN to drive enc_z high while
// position == 0 and (A,B) == 00. When the macro is undefined, enc_z is
// constant 0.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset_n   in   synchronous, active-low reset
//   target    in   [WIDTH]     requested position, captured on load
//   load      in   one-cycle strobe that captures target
//   period    in   [DIV_WIDTH] clocks per phase, sampled on entry to WAIT
//   enc_a     out  quadrature channel A (registered)
//   enc_b     out  quadrature channel B (registered)
//   enc_z     out  index channel (registered, optional)
//   position  out  [WIDTH]     current emitted count
//   busy      out  high while stepping toward the target
//   done      out  one-cycle pulse when the target is reached
module quad_gen #(
  parameter int WIDTH      = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int MIN_PERIOD = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     target,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 enc_z,
  output logic [WIDTH-1:0]     position,
  output logic                 busy,
  output logic                 done
);

  localparam logic [WIDTH-1:0]     HALF  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DIV_WIDTH-1:0] MIN_P = DIV_WIDTH'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, WAIT, STEP} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     tgt_reg, tgt_next;
  logic [WIDTH-1:0]     pos_reg, pos_next;
  logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
  logic [DIV_WIDTH-1:0] eff_reg, eff_next;
  logic                 a_reg, a_next;
  logic                 b_reg, b_next;
  logic                 done_reg, done_next;

  logic [DIV_WIDTH-1:0] eff_cand;
  logic [WIDTH-1:0]     diff;
  logic                 step_up;
  logic [WIDTH-1:0]     pos_step;
  logic [WIDTH-1:0]     cmp_tgt;

  // Clamp the requested period so a phase never gets shorter than the
  // downstream debounce history.
  assign eff_cand = (period < MIN_P) ? MIN_P : period;

  // Shortest-way direction: a distance of exactly half the range goes up.
  assign diff     = tgt_reg - pos_reg;
  assign step_up  = (diff <= HALF);
  assign pos_step = step_up ? pos_reg + WIDTH'(1) : pos_reg - WIDTH'(1);

  // A load landing on the STEP edge is judged against the post-step position.
  assign cmp_tgt  = load ? target : tgt_reg;

  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    pos_next   = pos_reg;
    cnt_next   = cnt_reg;
    eff_next   = eff_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          tgt_next = target;
          if (target != pos_reg) begin
            state_next = WAIT;
            cnt_next   = '0;
            eff_next   = eff_cand;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      WAIT: begin
        if (load) begin
          tgt_next = target;
        end
        if (load && (target == pos_reg)) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else if (cnt_reg == eff_reg - DIV_WIDTH'(1)) begin
          state_next = STEP;
        end else begin
          cnt_next = cnt_reg + DIV_WIDTH'(1);
        end
      end
      STEP: begin
        // Up: 00->10->11->01->00 ; down is the exact reverse.
        // Only one of A/B changes per step by construction.
        if (step_up) begin
          a_next = ~b_reg;
          b_next = a_reg;
        end else begin
          a_next = b_reg;
          b_next = ~a_reg;
        end
        pos_next = pos_step;
        tgt_next = cmp_tgt;
        if (pos_step == cmp_tgt) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = WAIT;
          cnt_next   = '0;
          eff_next   = eff_cand;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      tgt_reg   <= '0;
      pos_reg   <= '0;
      cnt_reg   <= '0;
      eff_reg   <= MIN_P;
      a_reg     <= 1'b0;
      b_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      pos_reg   <= pos_next;
      cnt_reg   <= cnt_next;
      eff_reg   <= eff_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      done_reg  <= done_next;
    end
  end

`ifdef QUAD_GEN_INDEX_EN
  logic z_reg;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      z_reg <= 1'b0;
    end else begin
      z_reg <= (pos_next == '0) && !a_next && !b_next;
    end
  end
  assign enc_z = z_reg;
`else
  assign enc_z = 1'b0;
`endif

  assign enc_a    = a_reg;
  assign enc_b    = b_reg;
  assign position = pos_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen -- directed self-checking bench for quad_gen (default build,
// index output disabled). Checks reset values, phase spacing, quadrature
// order in both directions, wrap-around, mid-motion retargeting, a load on
// the STEP edge, and reset during motion.
module tb_quad_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  target;
  logic        load;
  logic [15:0] period;
  logic        enc_a, enc_b, enc_z;
  logic [7:0]  position;
  logic        busy, done;

  always #5 clk = ~clk;

  quad_gen #(.WIDTH(8), .DIV_WIDTH(16), .MIN_PERIOD(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .target   (target),
    .load     (load),
    .period   (period),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .enc_z    (enc_z),
    .position (position),
    .busy     (busy),
    .done     (done)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Expected quadrature state: index into the up sequence, and position.
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int         exp_idx = 0;
  logic [7:0] exp_pos = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] t, input logic [15:0] p);
    target = t;
    period = p;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  // Clocks until (A,B) changes; bounded. Done must not pulse while waiting.
  task automatic wait_change(output int n);
    logic [1:0] prev;
    int spurious;
    prev     = {enc_a, enc_b};
    n        = 0;
    spurious = 0;
    do begin
      step();
      n++;
      if (({enc_a, enc_b} == prev) && done) spurious++;
    end while (({enc_a, enc_b} == prev) && (n < 300));
    chk("no_done_while_waiting", spurious, 0);
  endtask

  task automatic move(input bit up, input int ntr, input int first_gap,
                      input int gap, input bit final_done);
    int  n;
    bit  last;
    for (int i = 0; i < ntr; i++) begin
      wait_change(n);
      last = final_done && (i == ntr - 1);
      chk("phase_gap", n, (i == 0) ? first_gap : gap);
      exp_idx = up ? (exp_idx + 1) % 4 : (exp_idx + 3) % 4;
      exp_pos = up ? exp_pos + 8'd1 : exp_pos - 8'd1;
      chk("ab", {enc_a, enc_b}, seq[exp_idx]);
      chk("position", position, exp_pos);
      chk("done_at_step", done, last);
      chk("busy_at_step", busy, !last);
      $display("step %0d: ab=%b%b position=%0d busy=%0b done=%0b", i, enc_a, enc_b,
               position, busy, done);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    target  = 8'd0;
    period  = 16'd0;

    // Reset values
    step();
    step();
    chk("rst_a", enc_a, 0);
    chk("rst_b", enc_b, 0);
    chk("rst_z", enc_z, 0);
    chk("rst_pos", position, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    step();

    // Up to 3 with period 20: 21 clocks between changes
    pulse_load(8'd3, 16'd20);
    chk("busy_rise", busy, 1);
    chk("no_done_on_load", done, 0);
    chk("ab_before_first", {enc_a, enc_b}, 0);
    move(1'b1, 3, 21, 21, 1'b1);
    step();
    chk("done_one_cycle", done, 0);

    // Down to 2, then down through the wrap to 254 with period 0 (->16)
    pulse_load(8'd2, 16'd0);
    move(1'b0, 1, 17, 17, 1'b1);
    pulse_load(8'd254, 16'd0);
    move(1'b0, 4, 17, 17, 1'b1);

    // Load equal to position: done next edge, no motion
    pulse_load(8'd254, 16'd16);
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 0);
    chk("eq_ab", {enc_a, enc_b}, 2'b11);
    chk("eq_pos", position, 254);
    step();
    chk("eq_done_clear", done, 0);
    chk("eq_busy_low", busy, 0);

    // Up toward 100; at 40 retarget to 30 -> reverse, no spurious done
    pulse_load(8'd100, 16'd16);
    move(1'b1, 42, 17, 17, 1'b0);
    pulse_load(8'd30, 16'd16);
    move(1'b0, 10, 16, 17, 1'b1);
    chk("retarget_final", position, 30);

    // Reset mid-motion
    pulse_load(8'd100, 16'd16);
    move(1'b1, 2, 17, 17, 1'b0);
    repeat (5) step();
    reset_n = 1'b0;
    step();
    chk("mid_rst_a", enc_a, 0);
    chk("mid_rst_b", enc_b, 0);
    chk("mid_rst_z", enc_z, 0);
    chk("mid_rst_pos", position, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    // Reset overrides load
    target = 8'd5;
    load   = 1'b1;
    step();
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_pos", position, 0);
    load    = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    exp_idx = 0;
    exp_pos = 8'd0;

    // Wrap 0 -> 255 (down), then 255 -> 0 (up); period 3 clamps to 16
    pulse_load(8'd255, 16'd3);
    move(1'b0, 1, 17, 17, 1'b1);
    pulse_load(8'd0, 16'd16);
    move(1'b1, 1, 17, 17, 1'b1);

    // Load on the STEP edge equal to the post-step position
    pulse_load(8'd10, 16'd16);
    move(1'b1, 3, 17, 17, 1'b0);
    repeat (16) step();
    target = 8'd4;
    load   = 1'b1;
    step();
    load   = 1'b0;
    chk("coinc_pos", position, 4);
    chk("coinc_ab", {enc_a, enc_b}, 2'b00);
    chk("coinc_done", done, 1);
    chk("coinc_busy", busy, 0);
    exp_idx = 0;
    exp_pos = 8'd4;

    // Mid-motion load equal to current position
    pulse_load(8'd10, 16'd16);
    move(1'b1, 1, 17, 17, 1'b0);
    pulse_load(8'd5, 16'd16);
    chk("mid_eq_done", done, 1);
    chk("mid_eq_busy", busy, 0);
    chk("mid_eq_ab", {enc_a, enc_b}, 2'b10);
    chk("mid_eq_pos", position, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/quad_gen.md
QUAD_GEN -- requirements
Module: quad_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of target and position, matching the 8-bit encoder count.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of the period input.
REQ-003 SHALL have parameter MIN_PERIOD, default 16: minimum clocks per quadrature phase, so the phase outlasts an 8-deep debounce history.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 target  input  WIDTH  requested position, sampled on load.
REQ-007 load  input  1  one-cycle strobe that captures target.
REQ-008 period  input  DIV_WIDTH  clocks per phase transition, sampled each time WAIT is entered.
REQ-009 enc_a, enc_b  output  1 each  quadrature outputs, registered.
REQ-010 enc_z  output  1  index output, registered; see Configuration.
REQ-011 position  output  WIDTH  current emitted count.
REQ-012 busy  output  1  high while stepping toward the target.
REQ-013 done  output  1  one-cycle pulse when the target is reached.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and STEP, with transitions IDLE->WAIT, WAIT->STEP, STEP->WAIT and STEP->IDLE.
REQ-015 Load in IDLE with target != position: SHALL latch the target, enter WAIT and assert busy on the next edge.
REQ-016 Load in IDLE with target == position: SHALL stay in IDLE, keep busy low, produce no transitions, and pulse done on the next edge.
REQ-017 Effective period SHALL be max(period, MIN_PERIOD); period = 0 SHALL therefore yield MIN_PERIOD.
REQ-018 WAIT SHALL count 0..eff-1, then enter STEP.
REQ-019 Timing: the first enc_a/enc_b change SHALL occur exactly eff+1 cycles after the busy-asserting edge (eff cycles in WAIT, 1 cycle in STEP).
REQ-020 STEP SHALL update enc_a, enc_b and position on the same edge.
REQ-021 Direction rule: SHALL increment if ((target - position) mod 2^WIDTH) <= 2^(WIDTH-1); otherwise SHALL decrement.
REQ-022 The direction rule SHALL be re-evaluated at every STEP.
REQ-023 Increment sequence for (A,B) SHALL be 00->10->11->01->00.
REQ-024 Decrement sequence SHALL be the exact reverse of REQ-023.
REQ-025 Each phase transition SHALL change position by exactly 1, with modulo-2^WIDTH wrap (255+1 -> 0, 0-1 -> 255).
REQ-026 When a STEP makes position equal the target: SHALL go to IDLE, deassert busy and pulse done, all on that same edge.
REQ-027 Otherwise STEP SHALL return to WAIT with the counter cleared.
REQ-028 Load while busy SHALL replace the latched target without restarting the WAIT counter and SHALL NOT produce a done pulse.
REQ-029 If a mid-motion load equals the current position: SHALL return to IDLE and pulse done on the next edge.
REQ-030 If load coincides with a STEP edge, the new target SHALL be compared against the post-step position.
REQ-031 At most one phase transition SHALL occur per STEP; A and B SHALL never change on the same edge.

Reset
REQ-032 When reset_n is low at a rising edge: state SHALL become IDLE.
REQ-033 During reset, enc_a, enc_b, enc_z, busy and done SHALL be 0; position, latched target and WAIT counter SHALL be 0.
REQ-034 Reset SHALL take priority over load.
REQ-035 Reset asserted mid-motion SHALL abort the motion with no done pulse.

Configuration
REQ-036 Macro QUAD_GEN_INDEX_EN defined: enc_z SHALL be 1 exactly while position == 0 and (A,B) == 00, updated on the same edge as position.
REQ-037 Macro QUAD_GEN_INDEX_EN undefined: enc_z SHALL be tied to constant 0, with no index logic synthesized.

Verification
REQ-038 Reset, then load target=3 with period=20 -> busy rises next edge; (A,B) steps 10, 11, 01 with 21 clocks between changes; position 1, 2, 3; done pulses once on the edge position reaches 3.
REQ-039 From position 2, load target=254 with period=0 -> decrement direction (diff 252 > 128); 16-clock WAIT per phase; position wraps 0 -> 255 -> 254; 4 transitions total.
REQ-040 Load target equal to position -> done one cycle later, busy stays 0, enc_a/enc_b unchanged.
REQ-041 While moving up to target=100 at position 40, load target=30 -> direction reverses on the next STEP, no spurious done, final position 30.
REQ-042 Assert reset_n low mid-motion -> next edge: all outputs 0, state IDLE, no done pulse.
REQ-043 Loop quad_gen into the debounce/encoder chain with period=16, targets 0->200->10 -> encoder value tracks position exactly; with QUAD_GEN_INDEX_EN, enc_z high only at position 0.
